// File: rtl/uart_csr_bridge.sv
// uart_csr_bridge: turns read/write command frames arriving from a UART
// transceiver into single CSR bus transactions and sends the result
// (an ack for writes, four data bytes for reads) back through the transmitter.
module uart_csr_bridge #(
    parameter int unsigned clk_freq       = 50000000,
    parameter int unsigned timeout_cycles = 500000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_done,
    output logic [13:0] csr_a,
    output logic        csr_we,
    output logic [31:0] csr_do,
    input  logic [31:0] csr_di,
    output logic        busy
);

    // clk_freq is informational; a zero clock or zero timeout setting
    // degrades to a one-cycle inter-byte limit instead of a stuck frame.
    localparam int unsigned TIMEOUT_LIMIT =
        (clk_freq != 0 && timeout_cycles != 0) ? timeout_cycles : 1;
    localparam int TW = $clog2(TIMEOUT_LIMIT + 1);

    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] ACK_BYTE  = 8'h06;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_H,
        S_ADDR_L,
        S_WDATA,
        S_WR_STROBE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_CAP,
        S_TX,
        S_TX_WAIT
    } state_t;

    state_t        state;
    state_t        next_state;

    logic          is_write;     // command type latched from the CMD byte
    logic [1:0]    wcnt;         // write data bytes received so far
    logic [TW-1:0] tcnt;         // cycles since the last byte of this frame
    logic [31:0]   rd_shift;     // read bytes still waiting to be sent
    logic [1:0]    remaining;    // reply bytes left after the current one

    logic          cmd_valid;
    logic          in_frame;
    logic          timed_out;

    assign cmd_valid = (rx_data == CMD_READ) || (rx_data == CMD_WRITE);
    assign in_frame  = (state == S_ADDR_H) || (state == S_ADDR_L) || (state == S_WDATA);
    assign timed_out = (tcnt == TW'(TIMEOUT_LIMIT));

    // State register; reset returns the FSM to IDLE from any state.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (sys_rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the strobes and busy flag derived from state.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the case can infer a latch.
        next_state = state;
        csr_we     = 1'b0;
        tx_wr      = 1'b0;
        busy       = (state != S_IDLE);

        unique case (state)
            S_IDLE: begin
                if (rx_done && cmd_valid) begin
                    next_state = S_ADDR_H;
                end
            end
            S_ADDR_H: begin
                if (rx_done) begin
                    next_state = S_ADDR_L;
                end else if (timed_out) begin
                    next_state = S_IDLE;
                end
            end
            S_ADDR_L: begin
                if (rx_done) begin
                    next_state = is_write ? S_WDATA : S_RD_ISSUE;
                end else if (timed_out) begin
                    next_state = S_IDLE;
                end
            end
            S_WDATA: begin
                if (rx_done) begin
                    if (wcnt == 2'd3) begin
                        next_state = S_WR_STROBE;
                    end
                end else if (timed_out) begin
                    next_state = S_IDLE;
                end
            end
            S_WR_STROBE: begin
                csr_we     = 1'b1;
                next_state = S_TX;
            end
            S_RD_ISSUE: begin
                next_state = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                next_state = S_RD_CAP;
            end
            S_RD_CAP: begin
                next_state = S_TX;
            end
            S_TX: begin
                tx_wr      = 1'b1;
                next_state = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (tx_done) begin
                    next_state = (remaining != 2'd0) ? S_TX : S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Inter-byte timeout counter: runs only while a frame is being received
    // and restarts on every received byte.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tcnt <= '0;
        end else if (!in_frame || rx_done) begin
            tcnt <= '0;
        end else if (!timed_out) begin
            tcnt <= tcnt + TW'(1);
        end
    end

    // Frame capture: command type, address and write data. csr_a and csr_do
    // keep their last values between frames.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            is_write <= 1'b0;
            wcnt     <= 2'd0;
            csr_a    <= 14'd0;
            csr_do   <= 32'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    wcnt <= 2'd0;
                    if (rx_done && cmd_valid) begin
                        is_write <= (rx_data == CMD_WRITE);
                    end
                end
                S_ADDR_H: begin
                    if (rx_done) begin
                        csr_a[13:8] <= rx_data[5:0];
                    end
                end
                S_ADDR_L: begin
                    if (rx_done) begin
                        csr_a[7:0] <= rx_data;
                    end
                end
                S_WDATA: begin
                    if (rx_done) begin
                        csr_do <= {csr_do[23:0], rx_data};
                        wcnt   <= wcnt + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Reply path: loads the ack or the captured read word and feeds tx_data
    // one byte at a time, MSB first, as the transmitter finishes each byte.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tx_data   <= 8'd0;
            rd_shift  <= 32'd0;
            remaining <= 2'd0;
        end else begin
            unique case (state)
                S_WR_STROBE: begin
                    tx_data   <= ACK_BYTE;
                    remaining <= 2'd0;
                end
                S_RD_CAP: begin
                    tx_data   <= csr_di[31:24];
                    rd_shift  <= {csr_di[23:0], 8'h00};
                    remaining <= 2'd3;
                end
                S_TX_WAIT: begin
                    if (tx_done && remaining != 2'd0) begin
                        tx_data   <= rd_shift[31:24];
                        rd_shift  <= {rd_shift[23:0], 8'h00};
                        remaining <= remaining - 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_csr_bridge.sv
// Directed bench for uart_csr_bridge: drives command frames byte by byte,
// models a registered CSR slave and a UART transmitter, and checks the
// CSR strobes and reply bytes against hand-computed values.
module tb_uart_csr_bridge;

    localparam int TIMEOUT = 40;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_done = 1'b0;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_do;
    logic [31:0] csr_di = 32'h0;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    // Observations gathered by the monitors.
    logic [7:0]  txq[$];
    int          we_cnt  = 0;
    logic [13:0] we_a    = '0;
    logic [31:0] we_d    = '0;
    int          overlap = 0;
    bit          tx_pend = 0;
    int          tx_cnt  = 0;

    uart_csr_bridge #(
        .clk_freq       (50000000),
        .timeout_cycles (TIMEOUT)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .rx_data (rx_data),
        .rx_done (rx_done),
        .tx_data (tx_data),
        .tx_wr   (tx_wr),
        .tx_done (tx_done),
        .csr_a   (csr_a),
        .csr_we  (csr_we),
        .csr_do  (csr_do),
        .csr_di  (csr_di),
        .busy    (busy)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [31:0] slave_rd(input logic [13:0] a);
        case (a)
            14'h3C02: return 32'h12345678;
            14'h0000: return 32'h00000000;
            14'h3F07: return 32'hCAFEF00D;
            default:  return 32'hA5A5A5A5;
        endcase
    endfunction

    // CSR slave: read data registered one cycle after the address.
    always @(posedge sys_clk) csr_di <= slave_rd(csr_a);

    // Monitor for CSR write strobes.
    always @(negedge sys_clk) begin
        if (csr_we) begin
            we_cnt = we_cnt + 1;
            we_a   = csr_a;
            we_d   = csr_do;
        end
    end

    // Transmitter model: records each byte, answers tx_done six cycles
    // later, and flags any tx_wr issued before the previous tx_done.
    always @(negedge sys_clk) begin
        tx_done = 1'b0;
        if (sys_rst) begin
            tx_pend = 0;
        end else if (tx_wr) begin
            if (tx_pend) overlap = overlap + 1;
            txq.push_back(tx_data);
            tx_pend = 1;
            tx_cnt  = 6;
        end else if (tx_pend) begin
            tx_cnt = tx_cnt - 1;
            if (tx_cnt == 0) begin
                tx_done = 1'b1;
                tx_pend = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge sys_clk); #1;
        rx_data = b;
        rx_done = 1'b1;
        @(posedge sys_clk); #1;
        rx_done = 1'b0;
        repeat (2) @(posedge sys_clk);
    endtask

    task automatic clear_obs();
        txq.delete();
        we_cnt  = 0;
        overlap = 0;
    endtask

    task automatic wait_tx(input int n, input int bound);
        for (int i = 0; i < bound && txq.size() < n; i++) @(negedge sys_clk);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        for (int i = 0; i < bound && busy; i++) @(negedge sys_clk);
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_reply(input string tag, input logic [31:0] word);
        check({tag, "_count"}, txq.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < txq.size())
                check($sformatf("%s_byte%0d", tag, i), 32'(txq[i]), 32'(word[31-8*i -: 8]));
        end
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge sys_clk);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_tx_wr",   32'(tx_wr),   32'h0);
        check("rst_csr_a",   32'(csr_a),   32'h0);
        check("rst_csr_we",  32'(csr_we),  32'h0);
        check("rst_csr_do",  csr_do,       32'h0);
        check("rst_busy",    32'(busy),    32'h0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;

        // Write 0xDEADBEEF to 0x0001.
        clear_obs();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        wait_tx(1, 100);
        wait_idle("wr_idle", 100);
        check("wr_we_count", we_cnt, 32'd1);
        check("wr_addr", 32'(we_a), 32'h0001);
        check("wr_data", we_d, 32'hDEADBEEF);
        check("wr_tx_count", txq.size(), 32'd1);
        if (txq.size() > 0) check("wr_ack", 32'(txq[0]), 32'h06);

        // Read 0x3C02.
        clear_obs();
        send_byte(8'h01); send_byte(8'h3C); send_byte(8'h02);
        wait_tx(4, 300);
        wait_idle("rd_idle", 100);
        check_reply("rd", 32'h12345678);
        check("rd_no_we", we_cnt, 32'd0);
        check("rd_tx_order", overlap, 32'd0);

        // Invalid command byte is discarded, then a read of 0x0000.
        clear_obs();
        send_byte(8'h7F);
        @(negedge sys_clk);
        check("bad_cmd_busy", 32'(busy), 32'd0);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        wait_tx(4, 300);
        wait_idle("bad_idle", 100);
        check_reply("bad", 32'h00000000);

        // Partial write abandoned by timeout, then a read whose ADDR_H has
        // its ignored top bits set (0xFF -> 0x3F).
        clear_obs();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h05); send_byte(8'hAA);
        repeat (30) @(negedge sys_clk);
        check("to_still_busy", 32'(busy), 32'd1);
        repeat (TIMEOUT + 10 - 30) @(negedge sys_clk);
        check("to_idle", 32'(busy), 32'd0);
        check("to_no_we", we_cnt, 32'd0);
        check("to_no_tx", txq.size(), 32'd0);
        send_byte(8'h01); send_byte(8'hFF); send_byte(8'h07);
        wait_tx(4, 300);
        wait_idle("to_rd_idle", 100);
        check_reply("to_rd", 32'hCAFEF00D);

        // A byte arriving while the reply is in flight is dropped.
        clear_obs();
        send_byte(8'h01); send_byte(8'h3C); send_byte(8'h02);
        wait_tx(1, 100);
        send_byte(8'h02);
        wait_tx(4, 300);
        repeat (12) @(negedge sys_clk);
        check("drop_busy", 32'(busy), 32'd0);
        check_reply("drop", 32'h12345678);
        check("drop_tx_order", overlap, 32'd0);

        // Reset after the second write data byte: outputs clear at once.
        clear_obs();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h09);
        send_byte(8'h11); send_byte(8'h22);
        @(posedge sys_clk); #3;
        sys_rst = 1'b1;
        #1;
        check("mid_rst_csr_a",  32'(csr_a), 32'h0);
        check("mid_rst_csr_do", csr_do,     32'h0);
        check("mid_rst_busy",   32'(busy),  32'h0);
        check("mid_rst_tx_data", 32'(tx_data), 32'h0);
        repeat (2) @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        check("mid_rst_no_we", we_cnt, 32'd0);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h0A);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        wait_tx(1, 100);
        wait_idle("rewr_idle", 100);
        check("rewr_we_count", we_cnt, 32'd1);
        check("rewr_addr", 32'(we_a), 32'h000A);
        check("rewr_data", we_d, 32'h01020304);
        check("rewr_tx_count", txq.size(), 32'd1);
        if (txq.size() > 0) check("rewr_ack", 32'(txq[0]), 32'h06);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
